// File: rtl/alu_pkg.sv
// Shared opcode constants, control width, default EXEC wait counts and FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int CTRL_W       = 13;
    localparam int CNT_W        = 8;
    localparam int ADD_WAIT_DEF = 2;
    localparam int MUL_WAIT_DEF = 4;
    localparam int DIV_WAIT_DEF = 8;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_MUL  = 4'd4,
        OP_DIV  = 4'd5,
        OP_SHR  = 4'd6,
        OP_SHRA = 4'd7,
        OP_SHL  = 4'd8,
        OP_ROR  = 4'd9,
        OP_ROL  = 4'd10,
        OP_NEG  = 4'd11,
        OP_NOT  = 4'd12
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bus of the sequencer plus the operand/result path to the external ALU.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the sequencer is idle.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic              start;
    logic [3:0]        opcode;
    logic [31:0]       a_in;
    logic [31:0]       b_in;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       z_hi;
    logic [31:0]       z_lo;
    logic [63:0]       alu_result;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [CTRL_W-1:0] alu_control;

    modport master (
        output start, opcode, a_in, b_in, alu_result,
        input  busy, done, err, z_hi, z_lo, alu_a, alu_b, alu_control
    );

    modport slave (
        input  start, opcode, a_in, b_in, alu_result,
        output busy, done, err, z_hi, z_lo, alu_a, alu_b, alu_control
    );

endinterface

// File: rtl/alu_op_decode.sv
// Opcode decoder: one-hot ALU control, EXEC cycle count N and illegal-opcode flag.
// Latency: purely combinational.
// Backpressure: none.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int ADD_WAIT = ADD_WAIT_DEF,
    parameter int MUL_WAIT = MUL_WAIT_DEF,
    parameter int DIV_WAIT = DIV_WAIT_DEF
) (
    input  logic [3:0]        i_opcode,
    output logic [CTRL_W-1:0] o_control,
    output logic [CNT_W-1:0]  o_wait,
    output logic              o_illegal
);

    // Single-cycle ops default to N=1; arithmetic ops take their configured wait.
    always_comb begin
        o_control = '0;
        o_wait    = CNT_W'(1);
        o_illegal = 1'b0;
        case (i_opcode)
            OP_ADD, OP_SUB: o_wait = CNT_W'(ADD_WAIT);
            OP_MUL:         o_wait = CNT_W'(MUL_WAIT);
            OP_DIV:         o_wait = CNT_W'(DIV_WAIT);
            default:        o_wait = CNT_W'(1);
        endcase
        if (i_opcode > OP_NOT) begin
            o_illegal = 1'b1;
        end else begin
            o_control = CTRL_W'(1) << i_opcode;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer for an external multi-cycle ALU: latches operands, drives one-hot control for N cycles, captures result.
// Latency: start at edge k -> done pulse in cycle k+N+1 (illegal opcode: done+err in cycle k+1).
// Backpressure: start is ignored outside IDLE; nothing is queued.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int ADD_WAIT = ADD_WAIT_DEF,
    parameter int MUL_WAIT = MUL_WAIT_DEF,
    parameter int DIV_WAIT = DIV_WAIT_DEF
) (
    input  logic           i_clock,
    input  logic           i_clear,
    alu_sequencer_if.slave bus
);

    state_e            r_state;
    state_e            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_op;
    logic [31:0]       r_alu_a;
    logic [31:0]       r_alu_b;
    logic [31:0]       r_z_hi;
    logic [31:0]       r_z_lo;
    logic              r_err;

    logic [3:0]        w_dec_op;
    logic [CTRL_W-1:0] w_dec_ctrl;
    logic [CNT_W-1:0]  w_dec_wait;
    logic              w_dec_illegal;
    logic              w_accept;
    logic              w_capture;
    logic              w_reject;

    // In IDLE the decoder classifies the incoming opcode; afterwards it drives the latched one,
    // so late changes on the request bus cannot disturb the operation in flight.
    assign w_dec_op = (r_state == ST_IDLE) ? bus.opcode : r_op;

    alu_op_decode #(
        .ADD_WAIT (ADD_WAIT),
        .MUL_WAIT (MUL_WAIT),
        .DIV_WAIT (DIV_WAIT)
    ) u_decode (
        .i_opcode  (w_dec_op),
        .o_control (w_dec_ctrl),
        .o_wait    (w_dec_wait),
        .o_illegal (w_dec_illegal)
    );

    // Next-state logic and the accept/capture/reject strobes that steer the datapath.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (w_dec_illegal) begin
                        w_reject     = 1'b1;
                        w_next_state = ST_DONE;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register; clear overrides any pending transition.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand latch, wait counter, result capture and error flag.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_alu_a <= '0;
            r_alu_b <= '0;
            r_z_hi  <= '0;
            r_z_lo  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a <= bus.a_in;
                r_alu_b <= bus.b_in;
                r_op    <= bus.opcode;
                r_cnt   <= w_dec_wait - CNT_W'(1);
            end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
                r_cnt   <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                r_z_hi <= bus.alu_result[63:32];
                r_z_lo <= bus.alu_result[31:0];
            end
            // Only a rejected request leaves err set for the DONE cycle that follows it.
            r_err <= w_reject;
        end
    end

    assign bus.busy        = (r_state == ST_EXEC);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.err         = r_err && (r_state == ST_DONE);
    assign bus.alu_control = (r_state == ST_EXEC) ? w_dec_ctrl : '0;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.z_hi        = r_z_hi;
    assign bus.z_lo        = r_z_lo;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: behavioural ALU stand-in, transaction-level reference model,
// per-cycle compare on the falling edge, directed literal scenarios then randomized traffic.
module tb_alu_sequencer;

    localparam int ADD_W = 2;
    localparam int MUL_W = 4;
    localparam int DIV_W = 8;

    logic clk;
    logic clear;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    bit   chk_en   = 1'b0;

    alu_sequencer_if sif ();

    alu_sequencer #(
        .ADD_WAIT (ADD_W),
        .MUL_WAIT (MUL_W),
        .DIV_WAIT (DIV_W)
    ) dut (
        .i_clock (clk),
        .i_clear (clear),
        .bus     (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU semantics used both by the ALU stand-in and the expectation model.
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] aa = {32'b0, a};
        logic [63:0] bb = {32'b0, b};
        logic [63:0] dd = {a, a};
        logic [63:0] t;
        logic [31:0] s32;
        logic [4:0]  sh = b[4:0];
        case (op)
            4'd0:  return {32'b0, a & b};
            4'd1:  return {32'b0, a | b};
            4'd2:  return aa + bb;
            4'd3:  return aa - bb;
            4'd4:  return aa * bb;
            4'd5:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            4'd6:  return {32'b0, a >> sh};
            4'd7:  begin s32 = $signed(a) >>> sh; return {32'b0, s32}; end
            4'd8:  return {32'b0, a << sh};
            4'd9:  begin t = dd >> sh; return {32'b0, t[31:0]}; end
            4'd10: begin t = dd << sh; return {32'b0, t[63:32]}; end
            4'd11: return {32'b0, 32'd0 - a};
            4'd12: return {32'b0, ~b};
            default: return 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
    endfunction

    function automatic int wait_of(input logic [3:0] op);
        case (op)
            4'd2, 4'd3: return ADD_W;
            4'd4:       return MUL_W;
            4'd5:       return DIV_W;
            default:    return 1;
        endcase
    endfunction

    // ALU stand-in: answers only a clean one-hot control, otherwise returns a poison value.
    logic [63:0] alu_res_w;
    always_comb begin
        alu_res_w = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 13; i++) begin
            if (sif.alu_control == (13'd1 << i)) alu_res_w = ref_alu(4'(i), sif.alu_a, sif.alu_b);
        end
    end
    assign sif.alu_result = alu_res_w;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transaction takes N busy cycles then one done cycle.
    int          m_exec_left = 0;
    bit          m_done      = 1'b0;
    bit          m_err       = 1'b0;
    logic [3:0]  m_op        = '0;
    logic [31:0] m_a         = '0;
    logic [31:0] m_b         = '0;
    logic [31:0] m_zh        = '0;
    logic [31:0] m_zl        = '0;

    always @(posedge clk) begin
        if (clear) begin
            m_exec_left = 0; m_done = 1'b0; m_err = 1'b0;
            m_op = '0; m_a = '0; m_b = '0; m_zh = '0; m_zl = '0;
        end else if (m_exec_left > 0) begin
            m_exec_left--;
            if (m_exec_left == 0) begin
                {m_zh, m_zl} = ref_alu(m_op, m_a, m_b);
                m_done = 1'b1;
                m_err  = 1'b0;
            end
        end else if (m_done) begin
            m_done = 1'b0;
            m_err  = 1'b0;
        end else if (sif.start) begin
            if (sif.opcode > 4'd12) begin
                m_done = 1'b1;
                m_err  = 1'b1;
            end else begin
                m_op = sif.opcode; m_a = sif.a_in; m_b = sif.b_in;
                m_exec_left = wait_of(sif.opcode);
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_busy;
            logic [12:0] e_ctl;
            e_busy = (m_exec_left > 0);
            e_ctl  = e_busy ? (13'd1 << m_op) : 13'd0;
            chk("busy",    64'(sif.busy),        64'(e_busy));
            chk("done",    64'(sif.done),        64'(m_done));
            chk("err",     64'(sif.err),         64'(m_done && m_err));
            chk("alu_ctl", 64'(sif.alu_control), 64'(e_ctl));
            chk("alu_a",   64'(sif.alu_a),       64'(m_a));
            chk("alu_b",   64'(sif.alu_b),       64'(m_b));
            chk("z_hi",    64'(sif.z_hi),        64'(m_zh));
            chk("z_lo",    64'(sif.z_lo),        64'(m_zl));
            if (sif.done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; optionally re-pulse start with opcode 0 while busy.
    // Returns after the done cycle, having stepped back into IDLE.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit repulse, output int lat, output int busy_cnt,
                         output logic [12:0] ctl_or, output logic err_seen);
        sif.start = 1'b1; sif.opcode = op; sif.a_in = a; sif.b_in = b;
        lat = 0; busy_cnt = 0; ctl_or = '0; err_seen = 1'b0;
        do begin
            step();
            lat++;
            if (sif.busy) busy_cnt++;
            ctl_or |= sif.alu_control;
            sif.a_in = $urandom; sif.b_in = $urandom;
            if (repulse && sif.busy) begin
                sif.start = 1'b1; sif.opcode = 4'd0;
            end else begin
                sif.start = 1'b0; sif.opcode = 4'($urandom_range(0, 15));
            end
        end while (!sif.done && lat < 40);
        chk("done_reached", 64'(sif.done), 64'd1);
        err_seen = sif.err;
        sif.start = 1'b0;
        step();
    endtask

    initial begin
        int          lat, bcnt, d0;
        logic [12:0] cor;
        logic        errs;

        clear = 1'b1;
        sif.start = 1'b0; sif.opcode = '0; sif.a_in = '0; sif.b_in = '0;
        step();
        chk_en = 1'b1;
        step();
        clear = 1'b0;

        chk("rst_busy", 64'(sif.busy), 64'd0);
        chk("rst_done", 64'(sif.done), 64'd0);
        chk("rst_ctl",  64'(sif.alu_control), 64'd0);
        chk("rst_z",    {sif.z_hi, sif.z_lo}, 64'd0);
        step();

        // ADD carry into the high word.
        issue(4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, lat, bcnt, cor, errs);
        chk("add_lat",  64'(lat),  64'd3);
        chk("add_busy", 64'(bcnt), 64'd2);
        chk("add_ctl",  64'(cor),  64'h0004);
        chk("add_zhi",  64'(sif.z_hi), 64'h1);
        chk("add_zlo",  64'(sif.z_lo), 64'h0);

        // DIV: quotient low, remainder high.
        issue(4'd5, 32'd100, 32'd7, 1'b0, lat, bcnt, cor, errs);
        chk("div_lat",  64'(lat),  64'd9);
        chk("div_busy", 64'(bcnt), 64'd8);
        chk("div_zlo",  64'(sif.z_lo), 64'd14);
        chk("div_zhi",  64'(sif.z_hi), 64'd2);

        // AND preload, then an illegal opcode must leave Z alone.
        issue(4'd0, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, lat, bcnt, cor, errs);
        chk("and_zlo",  64'(sif.z_lo), 64'h0000_F000);
        issue(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, lat, bcnt, cor, errs);
        chk("ill_lat",  64'(lat),  64'd1);
        chk("ill_err",  64'(errs), 64'd1);
        chk("ill_ctl",  64'(cor),  64'd0);
        chk("ill_zlo",  64'(sif.z_lo), 64'h0000_F000);

        // MUL with start re-pulsed during EXEC: exactly one completion.
        d0 = done_cnt;
        issue(4'd4, 32'h0001_0000, 32'h0001_0000, 1'b1, lat, bcnt, cor, errs);
        step(); step();
        chk("mul_lat",   64'(lat),  64'd5);
        chk("mul_ctl",   64'(cor),  64'h0010);
        chk("mul_zhi",   64'(sif.z_hi), 64'h1);
        chk("mul_zlo",   64'(sif.z_lo), 64'h0);
        chk("mul_dones", 64'(done_cnt - d0), 64'd1);

        // clear in EXEC cycle 3 of a DIV aborts it silently.
        sif.start = 1'b1; sif.opcode = 4'd5; sif.a_in = 32'd1000; sif.b_in = 32'd3;
        step();
        sif.start = 1'b0;
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        d0 = done_cnt;
        chk("clr_busy", 64'(sif.busy), 64'd0);
        chk("clr_done", 64'(sif.done), 64'd0);
        chk("clr_ctl",  64'(sif.alu_control), 64'd0);
        chk("clr_ab",   {sif.alu_a, sif.alu_b}, 64'd0);
        chk("clr_z",    {sif.z_hi, sif.z_lo}, 64'd0);
        for (int i = 0; i < 10; i++) step();
        chk("clr_nodone", 64'(done_cnt - d0), 64'd0);
        issue(4'd12, 32'h5555_5555, 32'd0, 1'b0, lat, bcnt, cor, errs);
        chk("not_lat", 64'(lat), 64'd2);
        chk("not_zlo", 64'(sif.z_lo), 64'hFFFF_FFFF);

        // Randomized traffic: spurious starts, illegal opcodes, occasional clear.
        for (int c = 0; c < 3000; c++) begin
            sif.start  = ($urandom_range(0, 2) != 0);
            sif.opcode = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(13, 15))
                                                     : 4'($urandom_range(0, 12));
            sif.a_in   = $urandom;
            sif.b_in   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            clear      = ($urandom_range(0, 59) == 0);
            step();
        end
        clear = 1'b0;
        sif.start = 1'b0;
        for (int i = 0; i < 12; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: ADD_WAIT, default 2, EXEC cycles for ADD/SUB.
REQ-003 Parameter: MUL_WAIT, default 4, EXEC cycles for MUL.
REQ-004 Parameter: DIV_WAIT, default 8, EXEC cycles for DIV.
REQ-005 Port: clock  in  1  rising-edge clock.
REQ-006 Port: clear  in  1  synchronous active-high reset.
REQ-007 Port: start  in  1  request; sampled only in IDLE.
REQ-008 Port: opcode  in  4  operation select: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHRA, 8 SHL, 9 ROR, 10 ROL, 11 NEG, 12 NOT; 13-15 illegal.
REQ-009 Port: a_in, b_in  in  32 each  operands; sampled with start.
REQ-010 Port: alu_result  in  64  combinational result returned by the ALU.
REQ-011 Port: alu_a, alu_b  out  32 each  latched operands driven to the ALU.
REQ-012 Port: alu_control  out  13  one-hot ALU operation select.
REQ-013 Port: busy  out  1  high in EXEC.
REQ-014 Port: done  out  1  one-cycle completion pulse.
REQ-015 Port: err  out  1  qualifies done for an illegal opcode.
REQ-016 Port: z_hi, z_lo  out  32 each  result register; z_hi = alu_result[63:32], z_lo = alu_result[31:0].

Function
REQ-017 FSM states SHALL be IDLE, EXEC and DONE.
REQ-018 IDLE: start=1 with a legal opcode SHALL latch a_in->alu_a, b_in->alu_b and opcode, load the cycle counter with N-1, and go to EXEC.
REQ-019 N SHALL be 1 for AND, OR, shifts, rotates, NEG and NOT; ADD_WAIT for ADD/SUB; MUL_WAIT for MUL; DIV_WAIT for DIV.
REQ-020 EXEC: alu_control SHALL equal 1<<opcode, and alu_a/alu_b SHALL be held stable.
REQ-021 EXEC: the counter SHALL decrement each cycle.
REQ-022 EXEC with counter=0: the same edge SHALL load z_hi/z_lo from alu_result and go to DONE.
REQ-023 DONE SHALL last exactly one cycle: done=1, busy=0, alu_control=0; next state IDLE unconditionally.
REQ-024 Latency: start sampled at edge k -> EXEC for cycles k+1..k+N -> done=1 in cycle k+N+1 with z_hi/z_lo already valid.
REQ-025 alu_control SHALL be all-zero in IDLE and DONE.
REQ-026 start SHALL be ignored in EXEC and DONE; no queueing.
REQ-027 Illegal opcode in IDLE with start=1: go straight to DONE with done=1, err=1, z_hi/z_lo unchanged, alu_control never asserted.
REQ-028 err SHALL be 0 whenever done=0.
REQ-029 z_hi/z_lo SHALL hold their value until the next successful capture.
REQ-030 Changes on opcode, a_in or b_in after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-031 clear=1 at any edge, including mid-EXEC, SHALL force state IDLE.
REQ-032 clear=1 SHALL force busy=0, done=0, err=0, alu_control=0, alu_a=0, alu_b=0, z_hi=0, z_lo=0, counter=0.
REQ-033 clear SHALL take priority over start and over a pending capture.

Structure
REQ-034 Shared package alu_pkg SHALL hold the opcode constants, the 13-bit control width, and the default wait values.
REQ-035 Sub-module alu_op_decode SHALL be combinational: opcode -> one-hot control, wait count N, illegal flag.
REQ-036 The ALU SHALL NOT be instantiated inside alu_sequencer; it connects at the parent level.

Verification
REQ-037 ADD: A=0xFFFFFFFF, B=1, start at edge 0 -> alu_control=0x0004 in cycles 1-2; done in cycle 3; z_hi=0x1, z_lo=0x0.
REQ-038 DIV: A=100, B=7 -> busy for 8 cycles; done in cycle 9; z_lo=14, z_hi=2.
REQ-039 Illegal opcode 14 with Z preloaded by AND of 0xF0F0/0xFF00 -> done=1 and err=1 in the next cycle; z_lo stays 0xF000; alu_control stays 0.
REQ-040 MUL: A=0x10000, B=0x10000, with start re-pulsed carrying opcode 0 during EXEC -> only MUL completes; z_hi=0x1, z_lo=0x0; exactly one done pulse.
REQ-041 clear asserted in EXEC cycle 3 of a DIV -> next cycle IDLE, all outputs 0, no done pulse; a following NOT of B=0 yields z_lo=0xFFFFFFFF.
